// File: rtl/video_scanout.sv
// video_scanout: framebuffer scanout stage.
// Fetches one byte per 8-pixel character cell from synchronous-read RAM and
// shifts it out MSB-first on 'video'. The bitplane (red/green) is chosen per
// line from field_green, so alternating colour-shutter fields show each plane.
// Line and character addressing live here; the raster generator only supplies
// the field_start / line_start / active strobes.

module video_scanout #(
  parameter int LINES  = 240,
  parameter int CHARS  = 64,
  parameter int LINE_W = 8,
  parameter int CHAR_W = 6
) (
  input  logic                     clk_pixel,
  input  logic                     rst_n,
  input  logic                     field_start,
  input  logic                     line_start,
  input  logic                     active,
  input  logic                     field_green,
  output logic [LINE_W+CHAR_W:0]   mem_addr,
  output logic                     mem_en,
  input  logic [7:0]               mem_data,
  output logic                     video,
  output logic                     underrun
);

  localparam logic [LINE_W-1:0] LINES_MAX = LINE_W'(LINES);
  localparam logic [CHAR_W:0]   CHARS_MAX = (CHAR_W + 1)'(CHARS);
  localparam logic [CHAR_W:0]   CHAR_ONE  = (CHAR_W + 1)'(1);

  // Line addressing: next line to fetch, and the line currently being shown
  logic [LINE_W-1:0] line_ctr;
  logic [LINE_W-1:0] cur_line;
  logic              line_valid;
  logic              plane;

  // Character and pixel position within the current line
  logic [CHAR_W:0]   char_ctr;
  logic [2:0]        pix_ctr;

  // Pixel datapath: output shifter plus one-byte prefetch buffer
  logic [7:0]        shift;
  logic [7:0]        hold;
  logic              hold_valid;
  logic              rd_pend;

  // Derived control terms
  logic [LINE_W-1:0] fetch_line;
  logic              line_ok;
  logic [CHAR_W:0]   char_next;
  logic              cell_load;
  logic              cell_fetch;
  logic              cell_starved;

  // field_start in the same cycle as line_start forces the fetch onto line 0.
  assign fetch_line = field_start ? '0 : line_ctr;
  assign line_ok    = (fetch_line < LINES_MAX);
  assign char_next  = char_ctr + CHAR_ONE;

  // A cell boundary is the first pixel of each group of 8 within active.
  // A line_start overlapping active restarts the counters instead.
  assign cell_load    = active && !line_start && (pix_ctr == 3'd0);
  assign cell_fetch   = cell_load && line_valid && (char_next < CHARS_MAX);
  assign cell_starved = cell_load && !hold_valid && line_valid && (char_ctr < CHARS_MAX);

  // Line/character addressing and the framebuffer read strobe
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      line_ctr   <= '0;
      cur_line   <= '0;
      line_valid <= 1'b0;
      plane      <= 1'b0;
      char_ctr   <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      mem_en <= 1'b0;
      if (line_start) begin
        char_ctr   <= '0;
        plane      <= field_green;
        cur_line   <= fetch_line;
        line_valid <= line_ok;
        line_ctr   <= line_ok ? fetch_line + 1'b1 : LINES_MAX;
        if (line_ok) begin
          mem_en   <= 1'b1;
          mem_addr <= {field_green, fetch_line, {CHAR_W{1'b0}}};
        end
      end else begin
        if (field_start) begin
          line_ctr <= '0;
        end
        if (cell_load) begin
          if (char_ctr < CHARS_MAX) begin
            char_ctr <= char_next;
          end
          if (cell_fetch) begin
            mem_en   <= 1'b1;
            mem_addr <= {plane, cur_line, char_next[CHAR_W-1:0]};
          end
        end
      end
    end
  end

  // Capture read data one cycle after each strobe into the prefetch buffer
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend    <= 1'b0;
      hold       <= '0;
      hold_valid <= 1'b0;
    end else begin
      rd_pend <= mem_en;
      if (rd_pend) begin
        hold <= mem_data;
      end
      if (line_start) begin
        hold_valid <= 1'b0;
      end else if (rd_pend) begin
        hold_valid <= 1'b1;
      end else if (cell_load) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Serialize the held byte MSB-first and flag cells that found no data
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      video    <= 1'b0;
      shift    <= '0;
      pix_ctr  <= '0;
      underrun <= 1'b0;
    end else begin
      if (line_start || !active) begin
        video   <= 1'b0;
        pix_ctr <= '0;
      end else if (pix_ctr == 3'd0) begin
        if (hold_valid) begin
          video <= hold[7];
          shift <= {hold[6:0], 1'b0};
        end else begin
          video <= 1'b0;
          shift <= '0;
        end
        pix_ctr <= 3'd1;
      end else begin
        video   <= shift[7];
        shift   <= {shift[6:0], 1'b0};
        pix_ctr <= pix_ctr + 3'd1;
      end
      if (cell_starved) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout: directed + randomized bench for video_scanout.
// Each line is described by its plane, the gap from line_start to active,
// the active length and an optional mid-line reset point. Expected pixels and
// the expected fetch address list come from the plain arithmetic of the
// scanout rules applied to the bench's own framebuffer array.

module tb_video_scanout;

  localparam int LINES = 240;
  localparam int CHARS = 64;

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b0;
  logic        field_start = 1'b0;
  logic        line_start = 1'b0;
  logic        active = 1'b0;
  logic        field_green = 1'b0;
  logic [14:0] mem_addr;
  logic        mem_en;
  logic [7:0]  mem_data = 8'h00;
  logic        video;
  logic        underrun;

  logic [7:0]  ram [0:32767];

  int n_checks = 0;
  int n_fail = 0;
  int model_line = 0;
  bit model_under = 1'b0;

  video_scanout dut (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .field_start (field_start),
    .line_start  (line_start),
    .active      (active),
    .field_green (field_green),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_data    (mem_data),
    .video       (video),
    .underrun    (underrun)
  );

  // Pixel clock, ~20 MHz
  always #25 clk_pixel = ~clk_pixel;

  // Synchronous-read framebuffer, one-cycle latency
  always @(posedge clk_pixel) begin
    if (mem_en) mem_data <= ram[mem_addr];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pixel n of a line from the framebuffer contents
  function automatic logic pixel_of(input bit valid, input bit g, input int ln, input int gap, input int n);
    int c;
    int b;
    logic [7:0] byte_v;
    c = n / 8;
    b = n % 8;
    if (!valid || c >= CHARS || (c == 0 && gap < 3)) return 1'b0;
    byte_v = ram[{g, 8'(ln), 6'(c)}];
    return byte_v[7 - b];
  endfunction

  task automatic apply_field_start();
    @(negedge clk_pixel);
    field_start = 1'b1;
    @(negedge clk_pixel);
    field_start = 1'b0;
    model_line = 0;
  endtask

  // One line: line_start at step 0, active from step gap for len cycles
  task automatic apply_stimulus(input bit fs, input bit g, input int gap, input int len, input int rst_at);
    int ln;
    bit valid;
    bit rst_done;
    int nloads;
    int n;
    logic exp_v;
    logic [14:0] exp_q[$];
    logic [14:0] got_q[$];
    ln = fs ? 0 : model_line;
    valid = (ln < LINES);
    model_line = valid ? ln + 1 : LINES;
    if (valid) begin
      exp_q.push_back({g, 8'(ln), 6'd0});
      nloads = (len + 7) / 8;
      if (rst_at >= 0 && rst_at / 8 + 1 < nloads) nloads = rst_at / 8 + 1;
      for (int k = 0; k < nloads; k++) begin
        if (k + 1 < CHARS) exp_q.push_back({g, 8'(ln), 6'(k + 1)});
      end
      if (gap < 3 && len > 0) model_under = 1'b1;
    end
    rst_done = 1'b0;
    for (int i = 0; i < gap + len + 11; i++) begin
      @(negedge clk_pixel);
      n = i - gap - 1;
      exp_v = 1'b0;
      if (!rst_done && n >= 0 && n < len) exp_v = pixel_of(valid, g, ln, gap, n);
      check_output("video", 32'(video), 32'(exp_v));
      if (mem_en) got_q.push_back(mem_addr);
      if (rst_at >= 0 && n == rst_at && !rst_done) begin
        check_output("mem_en_pre_reset", 32'(mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("video_in_reset", 32'(video), 32'd0);
        check_output("mem_en_in_reset", 32'(mem_en), 32'd0);
        check_output("underrun_in_reset", 32'(underrun), 32'd0);
        rst_done = 1'b1;
        model_line = 0;
        model_under = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      line_start  = (i == 0);
      field_start = fs && (i == 0);
      field_green = (i == 0) ? g : 1'($urandom);
      active      = (i >= gap && i < gap + len);
    end
    check_output("fetch_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
      check_output("fetch_addr", 32'(got_q[j]), 32'(exp_q[j]));
    end
    check_output("underrun", 32'(underrun), 32'(model_under));
  endtask

  initial begin
    bit g;
    for (int a = 0; a < 32768; a++) ram[a] = 8'($urandom);
    for (int c = 0; c < CHARS; c++) begin
      ram[{1'b1, 8'd0, 6'(c)}] = 8'(c);
      ram[{1'b0, 8'd5, 6'(c)}] = 8'hA5;
    end

    // Reset state
    repeat (3) @(negedge clk_pixel);
    check_output("reset_video", 32'(video), 32'd0);
    check_output("reset_mem_en", 32'(mem_en), 32'd0);
    check_output("reset_mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;

    // Green line 0 with byte = char index
    apply_field_start();
    apply_stimulus(1'b0, 1'b1, 3, 512, -1);

    // Lines 1..4 short and random
    for (int l = 1; l < 5; l++)
      apply_stimulus(1'b0, 1'($urandom), int'($urandom_range(3, 6)), int'($urandom_range(1, 80)), -1);

    // Red line 5 holding 0xA5
    apply_stimulus(1'b0, 1'b0, 3, 512, -1);

    // Active overrun past the last cell
    apply_stimulus(1'b0, 1'($urandom), 4, 520, -1);

    // A few random full-ish lines
    for (int l = 0; l < 3; l++)
      apply_stimulus(1'b0, 1'($urandom), int'($urandom_range(3, 6)), int'($urandom_range(8, 520)), -1);

    // field_start coincident with line_start, then run off the end of the field
    apply_stimulus(1'b1, 1'b1, 3, 16, -1);
    for (int l = 1; l < LINES; l++)
      apply_stimulus(1'b0, 1'($urandom), 3, 16, -1);
    apply_stimulus(1'b0, 1'b1, 1, 40, -1);
    apply_stimulus(1'b0, 1'b0, 3, 40, -1);

    // New field fetches line 0 again
    apply_field_start();
    apply_stimulus(1'b0, 1'b1, 3, 64, -1);

    // line_start too close to active: first cell starves
    apply_stimulus(1'b0, 1'($urandom), 1, 64, -1);

    // Reset mid-line at pixel 200 on an all-ones line
    g = 1'($urandom);
    for (int c = 0; c < CHARS; c++) ram[{g, 8'(model_line), 6'(c)}] = 8'hFF;
    apply_stimulus(1'b0, g, 3, 300, 200);

    // Scanout resumes from line 0 after reset
    apply_stimulus(1'b0, 1'($urandom), 3, 512, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
